// File: rtl/cms_write_sequencer_if.sv
// Host-side write port and shared SAA1099 bus of the CMS write sequencer.
// Handshake: host_wr is a one-cycle push with no ready. A write that arrives while full=1 is dropped and latches overflow.
interface cms_write_sequencer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             host_wr;
  logic [1:0]       host_port;
  logic [7:0]       host_data;
  logic             flush;
  logic             ovf_clr;
  logic             full;
  logic [LVL_W-1:0] level;
  logic             busy;
  logic             overflow;
  logic [1:0]       saa_cs_n;
  logic             saa_a0;
  logic             saa_wr_n;
  logic [7:0]       saa_din;
  logic [2:0]       dbg_state;

  modport master (
    output host_wr, host_port, host_data, flush, ovf_clr,
    input  full, level, busy, overflow,
    input  saa_cs_n, saa_a0, saa_wr_n, saa_din, dbg_state
  );

  modport slave (
    input  host_wr, host_port, host_data, flush, ovf_clr,
    output full, level, busy, overflow,
    output saa_cs_n, saa_a0, saa_wr_n, saa_din, dbg_state
  );
endinterface

// File: rtl/cms_write_sequencer.sv
// Buffers host writes for the two SAA1099 chips and replays each one as a
// framed cs_n/a0/wr_n/din cycle with fixed setup, strobe, hold and recovery.
module cms_write_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int WR_LOW     = 2,
  parameter int WR_GAP     = 4
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  cms_write_sequencer_if.slave   bus_if
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int MAX_PH = (WR_LOW > WR_GAP) ? WR_LOW : WR_GAP;
  localparam int CNT_W  = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             overflow_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       ent_q;
  logic [1:0]       cs_n_q;
  logic             wr_n_q;
  logic             a0_q;
  logic [7:0]       din_q;

  logic full, push, drop, pop;

  assign full = (level_q == LVL_W'(FIFO_DEPTH));
  assign push = bus_if.host_wr && !full && !bus_if.flush;
  assign drop = bus_if.host_wr && full && !bus_if.flush;
  // Head leaves the FIFO when the bus is free: from IDLE, or on the last GAP cycle.
  assign pop  = !bus_if.flush && (level_q != '0) &&
                ((state_q == S_IDLE) || ((state_q == S_GAP) && (cnt_q == '0)));

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus_if.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !pop)      level_q <= level_q + LVL_W'(1);
        else if (!push && pop) level_q <= level_q - LVL_W'(1);
      end
      if (drop)                overflow_q <= 1'b1;
      else if (bus_if.ovf_clr) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= {bus_if.host_port, bus_if.host_data};
  end

  // Bus pins are a registered decode of the current state, so they lag the state by one cycle.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ent_q   <= '0;
      cs_n_q  <= 2'b11;
      wr_n_q  <= 1'b1;
      a0_q    <= 1'b0;
      din_q   <= 8'h00;
    end else begin
      case (state_q)
        S_SETUP: begin
          cs_n_q <= ent_q[9] ? 2'b01 : 2'b10;
          a0_q   <= ent_q[8];
          din_q  <= ent_q[7:0];
          wr_n_q <= 1'b1;
        end
        S_STROBE: wr_n_q <= 1'b0;
        S_HOLD:   wr_n_q <= 1'b1;
        default: begin
          cs_n_q <= 2'b11;
          wr_n_q <= 1'b1;
        end
      endcase

      if (pop) ent_q <= mem_q[rd_ptr_q];

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (pop) state_q <= S_SETUP;
        end
        S_SETUP: begin
          state_q <= S_STROBE;
          cnt_q   <= CNT_W'(WR_LOW - 1);
        end
        S_STROBE: begin
          if (cnt_q == '0) state_q <= S_HOLD;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        S_HOLD: begin
          state_q <= S_GAP;
          cnt_q   <= CNT_W'(WR_GAP - 1);
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= pop ? S_SETUP : S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus_if.full      = full;
  assign bus_if.level     = level_q;
  assign bus_if.busy      = (state_q != S_IDLE) || (level_q != '0);
  assign bus_if.overflow  = overflow_q;
  assign bus_if.saa_cs_n  = cs_n_q;
  assign bus_if.saa_a0    = a0_q;
  assign bus_if.saa_wr_n  = wr_n_q;
  assign bus_if.saa_din   = din_q;
  assign bus_if.dbg_state = state_q;
endmodule

// File: tb/tb_cms_write_sequencer.sv
// Randomized and directed bench for cms_write_sequencer against a queue-based
// model: FIFO as a queue, bus cycles as fixed-period pop slots.
module tb_cms_write_sequencer;
  localparam int DEPTH  = 8;
  localparam int WR_LOW = 2;
  localparam int WR_GAP = 4;
  localparam int PERIOD = 1 + WR_LOW + 1 + WR_GAP;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  cms_write_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus_if ();

  cms_write_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .WR_LOW    (WR_LOW),
    .WR_GAP    (WR_GAP)
  ) dut (
    .clk_sys(clk_sys),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // reference model state
  logic [9:0] m_q[$];
  logic [9:0] exp_q[$];
  int         exp_t_q[$];
  logic       m_ovf    = 1'b0;
  int         last_pop = -100;

  // bus monitor state
  logic        prev_wr = 1'b1;
  logic        in_low  = 1'b0;
  logic        gap_chk = 1'b0;
  int          low_cnt = 0;
  logic [10:0] cap     = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    logic       rst_seen, fl, wr, oc, fullb, drop, do_pop;
    logic [1:0] pt;
    logic [7:0] dt;
    logic [9:0] e;
    int         lvl0, t;
    rst_seen = !rst_n;
    fl = bus_if.flush;
    wr = bus_if.host_wr;
    oc = bus_if.ovf_clr;
    pt = bus_if.host_port;
    dt = bus_if.host_data;
    @(posedge clk_sys);
    cyc++;
    if (rst_seen) begin
      m_q.delete();
      exp_q.delete();
      exp_t_q.delete();
      m_ovf    = 1'b0;
      last_pop = -100;
    end else begin
      lvl0   = m_q.size();
      fullb  = (lvl0 == DEPTH);
      drop   = wr && fullb && !fl;
      do_pop = !fl && (lvl0 > 0) && (cyc >= last_pop + PERIOD);
      if (fl) begin
        m_q.delete();
      end else begin
        if (do_pop) begin
          e = m_q.pop_front();
          exp_q.push_back(e);
          exp_t_q.push_back(cyc + 2);
          last_pop = cyc;
        end
        if (wr && !fullb) m_q.push_back({pt, dt});
      end
      if (drop)    m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
    end
    #1;
    check("level", 32'(bus_if.level), 32'(m_q.size()));
    check("full", bus_if.full, m_q.size() == DEPTH);
    check("overflow", bus_if.overflow, m_ovf);
    check("busy", bus_if.busy, (m_q.size() != 0) || (cyc < last_pop + PERIOD));
    check("cs_excl", bus_if.saa_cs_n != 2'b00, 1'b1);
    if (rst_seen) begin
      check("rst_cs", bus_if.saa_cs_n, 2'b11);
      check("rst_wr", bus_if.saa_wr_n, 1'b1);
      check("rst_a0", bus_if.saa_a0, 1'b0);
      check("rst_din", bus_if.saa_din, 8'h00);
      prev_wr = 1'b1;
      in_low  = 1'b0;
      gap_chk = 1'b0;
    end else begin
      if (gap_chk) begin
        check("gap_cs", bus_if.saa_cs_n, 2'b11);
        gap_chk = 1'b0;
      end
      if (!bus_if.saa_wr_n)
        check("strobe_cs", (bus_if.saa_cs_n == 2'b10) || (bus_if.saa_cs_n == 2'b01), 1'b1);
      if (prev_wr && !bus_if.saa_wr_n) begin
        if (exp_q.size() == 0) begin
          check("stray_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          check("fall_time", cyc, t);
          check("cs", bus_if.saa_cs_n, e[9] ? 2'b01 : 2'b10);
          check("a0", bus_if.saa_a0, e[8]);
          check("din", bus_if.saa_din, e[7:0]);
        end
        cap     = {bus_if.saa_cs_n, bus_if.saa_a0, bus_if.saa_din};
        low_cnt = 1;
        in_low  = 1'b1;
      end else if (!bus_if.saa_wr_n) begin
        low_cnt++;
      end else if (!prev_wr && in_low) begin
        check("wr_low_len", low_cnt, WR_LOW);
        check("hold_stable", {bus_if.saa_cs_n, bus_if.saa_a0, bus_if.saa_din}, cap);
        in_low  = 1'b0;
        gap_chk = 1'b1;
      end
      prev_wr = bus_if.saa_wr_n;
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    bus_if.host_wr = 1'b0;
    bus_if.flush   = 1'b0;
    bus_if.ovf_clr = 1'b0;
    repeat (n) tick();
  endtask

  task automatic host_write(input logic [1:0] p, input logic [7:0] d, input logic clr);
    bus_if.host_wr   = 1'b1;
    bus_if.host_port = p;
    bus_if.host_data = d;
    bus_if.ovf_clr   = clr;
    tick();
    bus_if.host_wr = 1'b0;
    bus_if.ovf_clr = 1'b0;
  endtask

  initial begin
    bus_if.host_wr   = 1'b0;
    bus_if.host_port = 2'b00;
    bus_if.host_data = 8'h00;
    bus_if.flush     = 1'b0;
    bus_if.ovf_clr   = 1'b0;

    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // single address write to chip 0
    host_write(2'b01, 8'h1C, 1'b0);
    idle(20);
    check("idle_after_single", bus_if.busy, 1'b0);

    // four-write burst across both chips
    host_write(2'b01, 8'h18, 1'b0);
    host_write(2'b00, 8'h82, 1'b0);
    host_write(2'b11, 8'h19, 1'b0);
    host_write(2'b10, 8'h96, 1'b0);
    idle(45);

    // ten back-to-back writes: one must be dropped
    for (int i = 0; i < 10; i++) host_write(2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
    check("ovf_after_10", bus_if.overflow, 1'b1);
    idle(100);
    host_write(2'b00, 8'h00, 1'b1);
    idle(20);

    // push and pop in the same cycle at level 3
    for (int i = 0; i < 4; i++) host_write(2'b10, 8'(8'h40 + i), 1'b0);
    idle(5);
    host_write(2'b11, 8'h55, 1'b0);
    check("pushpop_lvl3", 32'(bus_if.level), 3);

    // fill, drop one, then drop again together with ovf_clr
    for (int i = 0; i < 5; i++) host_write(2'b01, 8'(8'h60 + i), 1'b0);
    host_write(2'b00, 8'hEE, 1'b0);
    check("ovf_set", bus_if.overflow, 1'b1);
    host_write(2'b00, 8'hEF, 1'b1);
    check("ovf_set_wins", bus_if.overflow, 1'b1);
    bus_if.ovf_clr = 1'b1;
    tick();
    bus_if.ovf_clr = 1'b0;
    check("ovf_cleared", bus_if.overflow, 1'b0);
    idle(90);

    // flush during a strobe with five entries queued
    for (int i = 0; i < 7; i++) host_write(2'b00, 8'(8'h70 + i), 1'b0);
    idle(4);
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    check("flush_level", 32'(bus_if.level), 0);
    idle(30);

    // reset in the middle of a strobe
    for (int i = 0; i < 3; i++) host_write(2'b11, 8'(8'h90 + i), 1'b0);
    idle(1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_wr", bus_if.saa_wr_n, 1'b1);
    check("rst_mid_lvl", 32'(bus_if.level), 0);
    idle(2);
    host_write(2'b10, 8'hA5, 1'b0);
    idle(20);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus_if.host_wr   = ($urandom_range(0, 99) < 40);
      bus_if.host_port = 2'($urandom_range(0, 3));
      bus_if.host_data = 8'($urandom);
      bus_if.flush     = ($urandom_range(0, 99) < 2);
      bus_if.ovf_clr   = ($urandom_range(0, 99) < 5);
      tick();
    end
    idle(120);
    check("drain", 32'(exp_q.size()), 0);
    check("final_idle", bus_if.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
